// File: rtl/fu_arbiter_pkg.sv
// Shared types and constants for the two-requester functional-unit arbiter.
package fu_arbiter_pkg;

  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  localparam logic [2:0] OpAdd    = 3'd0;
  localparam logic [2:0] OpAddInv = 3'd1;
  localparam logic [2:0] OpAnd    = 3'd2;
  localparam logic [2:0] OpOr     = 3'd3;
  localparam logic [2:0] OpMax    = 3'd4;
  localparam logic [2:0] OpMin    = 3'd5;
  localparam logic [2:0] OpShrAdd = 3'd6;
  localparam logic [2:0] OpShlAdd = 3'd7;

  // Index of the highest set bit; zero when no bit is set.
  function automatic logic [2:0] top_bit(input logic [DW-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fu_arbiter_if.sv
// Request, response and counter signals of the functional-unit arbiter.
interface fu_arbiter_if;
  import fu_arbiter_pkg::*;

  logic          req0_valid;
  logic          req0_ready;
  logic [DW-1:0] req0_instr;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic [DW-1:0] req0_c;
  logic          req1_valid;
  logic          req1_ready;
  logic [DW-1:0] req1_instr;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic [DW-1:0] req1_c;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_id;
  logic          rsp_err;
  logic [DW-1:0] cnt0;
  logic [DW-1:0] cnt1;

  modport slave (
    input  req0_valid, req0_instr, req0_a, req0_b, req0_c,
    input  req1_valid, req1_instr, req1_a, req1_b, req1_c,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_err, cnt0, cnt1
  );

  modport master (
    output req0_valid, req0_instr, req0_a, req0_b, req0_c,
    output req1_valid, req1_instr, req1_a, req1_b, req1_c,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_err, cnt0, cnt1
  );

endinterface

// File: rtl/fu_op_eval.sv
// Combinational decode of the priority instruction word and operand evaluation.
module fu_op_eval
  import fu_arbiter_pkg::*;
(
  input  logic [DW-1:0] instr_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] c_i,
  output logic [DW-1:0] result_o,
  output logic          err_o
);

  logic [2:0]    op;
  logic          a_lt_c;

  always_comb begin
    op       = top_bit(instr_i);
    err_o    = (instr_i == '0);
    a_lt_c   = (a_i < c_i);
    result_o = '0;
    if (!err_o) begin
      case (op)
        OpShlAdd: result_o = {c_i[DW-2:0], 1'b0} + a_i;
        OpShrAdd: result_o = (a_i >> 1) + b_i;
        OpMin:    result_o = a_lt_c ? a_i : c_i;
        OpMax:    result_o = a_lt_c ? c_i : a_i;
        OpOr:     result_o = b_i | c_i;
        OpAnd:    result_o = c_i & a_i;
        OpAddInv: result_o = c_i + ~a_i;
        OpAdd:    result_o = c_i + a_i;
      endcase
    end
  end

endmodule

// File: rtl/fu_arbiter.sv
// Round-robin arbiter feeding one shared functional unit: accept, execute one cycle, respond.
module fu_arbiter
  import fu_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fu_arbiter_if.slave  bus_io
);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          id_q;
  logic [DW-1:0] instr_q, a_q, b_q, c_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_id_q, rsp_err_q;
  logic [DW-1:0] cnt0_q, cnt1_q;
  logic          grant, accept, handshake;
  logic [DW-1:0] op_result;
  logic          op_err;

  fu_op_eval u_op_eval (
    .instr_i  (instr_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .c_i      (c_q),
    .result_o (op_result),
    .err_o    (op_err)
  );

  always_comb begin
    state_d           = state_q;
    last_d            = last_q;
    accept            = 1'b0;
    handshake         = 1'b0;
    bus_io.req0_ready = 1'b0;
    bus_io.req1_ready = 1'b0;
    bus_io.rsp_valid  = 1'b0;
    // A lone requester wins outright; otherwise favour the one not served last.
    grant = (bus_io.req0_valid ^ bus_io.req1_valid) ? bus_io.req1_valid : ~last_q;
    case (state_q)
      StIdle: begin
        bus_io.req0_ready = !rst && !grant;
        bus_io.req1_ready = !rst && grant;
        accept = (bus_io.req0_ready && bus_io.req0_valid) ||
                 (bus_io.req1_ready && bus_io.req1_valid);
        if (accept) state_d = StExec;
      end
      StExec: state_d = StResp;
      StResp: begin
        bus_io.rsp_valid = 1'b1;
        if (bus_io.rsp_ready) begin
          handshake = 1'b1;
          last_d    = rsp_id_q;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      instr_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      if (accept) begin
        id_q    <= grant;
        instr_q <= grant ? bus_io.req1_instr : bus_io.req0_instr;
        a_q     <= grant ? bus_io.req1_a     : bus_io.req0_a;
        b_q     <= grant ? bus_io.req1_b     : bus_io.req0_b;
        c_q     <= grant ? bus_io.req1_c     : bus_io.req0_c;
      end
      if (state_q == StExec) begin
        rsp_data_q <= op_result;
        rsp_err_q  <= op_err;
        rsp_id_q   <= id_q;
      end
      if (handshake) begin
        if (rsp_id_q) cnt1_q <= cnt1_q + 1'b1;
        else          cnt0_q <= cnt0_q + 1'b1;
      end
    end
  end

  assign bus_io.rsp_data = rsp_data_q;
  assign bus_io.rsp_id   = rsp_id_q;
  assign bus_io.rsp_err  = rsp_err_q;
  assign bus_io.cnt0     = cnt0_q;
  assign bus_io.cnt1     = cnt1_q;

endmodule

// File: doc/fu_arbiter.md
FU_ARBITER -- requirements
Module: fu_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 (rising edge), rst input 1 (synchronous, active-high).
REQ-002 req0_valid / req1_valid SHALL be 1-bit inputs: the requester's command is present.
REQ-003 req0_ready / req1_ready SHALL be 1-bit outputs: the command is accepted on the edge where valid and ready are both high.
REQ-004 req0_instr / req1_instr SHALL be 8-bit one-hot-priority instruction inputs.
REQ-005 req0_a/b/c and req1_a/b/c SHALL be 8-bit operand inputs.
REQ-006 rsp_valid (output, 1), rsp_ready (input, 1), rsp_data (output, 8), rsp_id (output, 1, requester index) and rsp_err (output, 1, illegal instruction) SHALL form the response port.
REQ-007 cnt0 / cnt1 SHALL be 8-bit outputs counting completed responses per requester.

Function
REQ-008 The FSM SHALL have exactly three states: IDLE, EXEC and RESP; reset enters IDLE.
REQ-009 In IDLE, reqN_ready SHALL be 1 only for the granted requester; in EXEC and RESP both readys SHALL be 0.
REQ-010 Arbitration SHALL be round-robin: when both requesters are valid, grant goes to the one not served last; when only one is valid, it is granted.
REQ-011 The last-served pointer SHALL reset to 1, so req0 wins the first tie.
REQ-012 On accept, the block SHALL latch instr/a/b/c and the id, then go IDLE->EXEC.
REQ-013 Decode SHALL use the highest set instr bit k to select op k; instr==8'h00 SHALL set err=1 and result 0.
REQ-014 The op set SHALL be, with all results truncated to 8 bits:
  - op7 (C<<1)+A
  - op6 (A>>1)+B
  - op5 min(A,C), unsigned
  - op4 max(C,A), unsigned
  - op3 B|C
  - op2 C&A
  - op1 C+~A
  - op0 C+A
REQ-015 EXEC SHALL last exactly one cycle, register the result/err/id and go to RESP.
REQ-016 In RESP, rsp_valid SHALL be 1; rsp_data, rsp_id and rsp_err SHALL hold stable until rsp_ready is sampled high.
REQ-017 The response handshake SHALL increment cnt[rsp_id] (wrapping 8'hFF->8'h00), update the last-served pointer and return to IDLE.
REQ-018 New acceptance SHALL NOT occur in the handshake cycle; minimum spacing between accepts is 3 cycles.
REQ-019 Outside RESP, rsp_valid SHALL be 0 and rsp_data/rsp_id/rsp_err SHALL retain their last values.
REQ-020 A requester dropping valid while not granted SHALL have no effect; granted operands SHALL be sampled only at the accept edge.

Reset
REQ-021 rst SHALL force, on the next edge and from any state including EXEC and RESP:
  - state = IDLE
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_err = 0
  - cnt0 = cnt1 = 0
  - last-served pointer = 1
  - latched operands = 0
REQ-022 Any in-flight command SHALL be discarded by reset with no response.
REQ-023 Readys SHALL be 0 while rst is high.

Structure
REQ-024 A shared package SHALL hold the state enum (IDLE/EXEC/RESP), the 3-bit op codes and the width constant DW=8.
REQ-025 The decode and op evaluation SHALL be one combinational sub-module, fu_op_eval (inputs instr, a, b, c; outputs result, err); arbitration and FSM SHALL stay in fu_arbiter.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
  - req0 instr=8'h80, A=3, C=5 -> rsp_data=13, rsp_id=0, rsp_err=0, rsp_valid 2 cycles after accept.
  - req1 instr=8'h41, A=9, B=1 -> op6 chosen by priority, rsp_data=5, rsp_id=1.
  - instr=8'h02, A=3, C=5 -> rsp_data=1 (wrap); instr=8'h00 -> rsp_err=1, rsp_data=0.
  - Both valid from reset, rsp_ready=1 -> order req0, req1, req0, req1; cnt0=cnt1=2.
  - rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, both readys 0, no count change until handshake.
  - rst asserted in EXEC -> no response, cnt unchanged at 0, req0_ready high the cycle after rst drops.
